// File: rtl/iram_pkg.sv
// Shared encodings and sizes for the internal RAM responder.
package iram_pkg;

    localparam int unsigned IRAM_DEPTH = 128;
    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned CMD_W      = 5;

    localparam logic [DATA_W-1:0] ERR_DATA = 8'hFF;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP    = 5'h00,
        CMD_RD_DIR = 5'h01,
        CMD_WR_DIR = 5'h02,
        CMD_RD_RN  = 5'h03,
        CMD_WR_RN  = 5'h04,
        CMD_RD_IND = 5'h05,
        CMD_WR_IND = 5'h06
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PTR  = 2'd1,
        ST_ACC  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Codes above WR_IND are illegal
    function automatic logic cmd_is_legal(input logic [CMD_W-1:0] c);
        return c <= CMD_WR_IND;
    endfunction

    function automatic logic cmd_is_write(input logic [CMD_W-1:0] c);
        return (c == CMD_WR_DIR) || (c == CMD_WR_RN) || (c == CMD_WR_IND);
    endfunction

    function automatic logic cmd_is_read(input logic [CMD_W-1:0] c);
        return (c == CMD_RD_DIR) || (c == CMD_RD_RN) || (c == CMD_RD_IND);
    endfunction

    function automatic logic cmd_is_ind(input logic [CMD_W-1:0] c);
        return (c == CMD_RD_IND) || (c == CMD_WR_IND);
    endfunction

endpackage

// File: rtl/iram_array.sv
// 128x8 storage: one synchronous write port, one combinational read port, no reset.
module iram_array
    import iram_pkg::*;
(
    input  logic              clock,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [IRAM_DEPTH];

    // Write port; contents deliberately survive reset
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/iram_responder.sv
// Internal RAM responder: accepts one access at a time, resolves direct/Rn/@Ri
// addressing, performs the access and reports completion with a done pulse.
module iram_responder
    import iram_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic [CMD_W-1:0]  RAM_access,
    input  logic [7:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        bank,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    state_e            r_state;
    logic [CMD_W-1:0]  r_cmd;
    logic [7:0]        r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_bank;
    logic [7:0]        r_ptr;
    logic [DATA_W-1:0] r_rcap;
    logic              r_errp;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;

    logic [7:0]        w_eff_addr;
    logic [ADDR_W-1:0] w_ptr_addr;
    logic [ADDR_W-1:0] w_raddr;
    logic [DATA_W-1:0] w_rd;
    logic              w_fault;
    logic              w_we;

    // Effective address of the latched command
    always_comb begin
        w_eff_addr = r_addr;
        case (r_cmd)
            CMD_RD_RN, CMD_WR_RN:   w_eff_addr = 8'({r_bank, r_addr[2:0]});
            CMD_RD_IND, CMD_WR_IND: w_eff_addr = r_ptr;
            default:                w_eff_addr = r_addr;
        endcase
    end

    // @Ri only ever looks at R0/R1 of the latched bank
    assign w_ptr_addr = ADDR_W'({r_bank, 2'b00, r_addr[0]});
    assign w_raddr    = (r_state == ST_PTR) ? w_ptr_addr : w_eff_addr[ADDR_W-1:0];

    // NOP never faults even if addr happens to be high
    assign w_fault = !cmd_is_legal(r_cmd) ||
                     ((r_cmd != CMD_NOP) && w_eff_addr[7]);

    // Reset at the ACC edge abandons the write
    assign w_we = (r_state == ST_ACC) && cmd_is_write(r_cmd) && !w_fault && !reset;

    iram_array u_array (
        .clock   (clock),
        .i_we    (w_we),
        .i_waddr (w_eff_addr[ADDR_W-1:0]),
        .i_wdata (r_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rd)
    );

    // Access sequencer with registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_bank  <= '0;
            r_ptr   <= '0;
            r_rcap  <= '0;
            r_errp  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (r_busy) begin
                        // Done cycle: still busy, request ignored
                        r_busy <= 1'b0;
                    end else if (req) begin
                        r_cmd   <= RAM_access;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_bank  <= bank;
                        r_busy  <= 1'b1;
                        r_state <= cmd_is_ind(RAM_access) ? ST_PTR : ST_ACC;
                    end
                end
                ST_PTR: begin
                    r_ptr   <= w_rd;
                    r_state <= ST_ACC;
                end
                ST_ACC: begin
                    r_rcap  <= w_rd;
                    r_errp  <= w_fault;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_done <= 1'b1;
                    r_err  <= r_errp;
                    if (r_errp) begin
                        r_rdata <= ERR_DATA;
                    end else if (cmd_is_read(r_cmd)) begin
                        r_rdata <= r_rcap;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign err   = r_err;
    assign rdata = r_rdata;

endmodule

// File: tb/tb_iram_responder.sv
// Randomized self-checking bench for iram_responder with a behavioural memory model.
module tb_iram_responder;

    logic       clock;
    logic       reset;
    logic       req;
    logic [4:0] RAM_access;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [1:0] bank;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mdl [128];
    logic [7:0] exp_rdata;

    iram_responder dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .RAM_access (RAM_access),
        .addr       (addr),
        .wdata      (wdata),
        .bank       (bank),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one access (caller is just after a rising edge) and check it end to end
    task automatic run_txn(input logic [4:0] cmd, input logic [7:0] a,
                           input logic [7:0] d, input logic [1:0] b);
        logic [7:0] ea;
        logic       ind, legal, fault, is_rd, is_wr;
        int         lat, exp_lat;
        logic       seen;

        ind   = (cmd == 5'd5) || (cmd == 5'd6);
        legal = (cmd <= 5'd6);
        is_rd = (cmd == 5'd1) || (cmd == 5'd3) || (cmd == 5'd5);
        is_wr = (cmd == 5'd2) || (cmd == 5'd4) || (cmd == 5'd6);
        if (cmd == 5'd3 || cmd == 5'd4)
            ea = {3'b000, b, a[2:0]};
        else if (ind)
            ea = mdl[{b, 2'b00, a[0]}];
        else
            ea = a;
        fault   = !legal || ((cmd != 5'd0) && (ea >= 8'h80));
        exp_lat = ind ? 4 : 3;

        req = 1'b1; RAM_access = cmd; addr = a; wdata = d; bank = b;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 8) begin
            @(posedge clock); #1;
            lat++;
            if (done) begin
                seen = 1'b1;
            end else begin
                check("busy_in_flight", busy, 1'b1);
                // Requests while busy must be ignored
                req        = 1'($urandom_range(0, 1));
                RAM_access = 5'($urandom);
                addr       = 8'($urandom);
                wdata      = 8'($urandom);
                bank       = 2'($urandom);
            end
        end
        req = 1'b0;
        check("done_seen", seen, 1'b1);
        check("latency", lat, exp_lat);
        check("busy_at_done", busy, 1'b1);

        if (fault)
            exp_rdata = 8'hFF;
        else if (is_rd)
            exp_rdata = mdl[ea[6:0]];
        if (is_wr && !fault)
            mdl[ea[6:0]] = d;
        check("err", err, fault);
        check("rdata", rdata, exp_rdata);

        @(posedge clock); #1;
        check("done_pulse_end", done, 1'b0);
        check("busy_release", busy, 1'b0);
        check("rdata_hold", rdata, exp_rdata);
    endtask

    initial begin
        logic [4:0] c;
        logic [7:0] a;
        int         r;

        reset = 1'b1; req = 1'b0; RAM_access = '0; addr = '0; wdata = '0; bank = '0;
        exp_rdata = 8'h00;
        @(posedge clock); @(posedge clock); #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rdata", rdata, 8'h00);

        // Reset wins over a simultaneous request
        req = 1'b1; RAM_access = 5'd2; addr = 8'h05; wdata = 8'h3C;
        @(posedge clock); #1;
        check("rst_vs_req_busy", busy, 1'b0);
        reset = 1'b0; req = 1'b0;
        @(posedge clock); #1;
        check("idle_busy", busy, 1'b0);

        // Give every location a known value
        for (int i = 0; i < 128; i++)
            run_txn(5'd2, 8'(i), 8'($urandom), 2'd0);

        // Direct write then read
        run_txn(5'd2, 8'h30, 8'hA5, 2'd0);
        run_txn(5'd1, 8'h30, 8'h00, 2'd0);
        check("dir_readback", rdata, 8'hA5);

        // Rn write in bank 2 seen through direct 0x13
        run_txn(5'd4, 8'h03, 8'h5C, 2'd2);
        run_txn(5'd1, 8'h13, 8'h00, 2'd0);
        check("rn_readback", rdata, 8'h5C);

        // @R1 of bank 1 points at 0x40
        run_txn(5'd4, 8'h01, 8'h40, 2'd1);
        run_txn(5'd2, 8'h40, 8'h77, 2'd0);
        run_txn(5'd5, 8'h01, 8'h00, 2'd1);
        check("ind_readback", rdata, 8'h77);

        // Out-of-range and illegal accesses
        run_txn(5'd1, 8'h90, 8'h00, 2'd0);
        run_txn(5'd2, 8'h90, 8'h33, 2'd0);
        run_txn(5'd1, 8'h10, 8'h00, 2'd0);
        run_txn(5'h1F, 8'h10, 8'h44, 2'd0);
        run_txn(5'd4, 8'h00, 8'hC0, 2'd0);
        run_txn(5'd5, 8'h00, 8'h00, 2'd0);
        run_txn(5'd6, 8'h00, 8'h55, 2'd0);
        run_txn(5'd1, 8'h40, 8'h00, 2'd0);
        run_txn(5'd0, 8'hF0, 8'h00, 2'd0);

        // Reset during ACC of a write abandons it
        req = 1'b1; RAM_access = 5'd2; addr = 8'h20; wdata = 8'h11; bank = 2'd0;
        @(posedge clock); #1;
        check("abort_busy", busy, 1'b1);
        req = 1'b1; RAM_access = 5'd2; addr = 8'h20; wdata = 8'h99;
        reset = 1'b1;
        @(posedge clock); #1;
        check("abort_busy0", busy, 1'b0);
        check("abort_done0", done, 1'b0);
        check("abort_err0", err, 1'b0);
        check("abort_rdata0", rdata, 8'h00);
        exp_rdata = 8'h00;
        reset = 1'b0; req = 1'b0;
        @(posedge clock); #1;
        check("abort_idle", busy, 1'b0);
        run_txn(5'd1, 8'h20, 8'h00, 2'd0);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0:       c = 5'd0;
                7:       c = 5'($urandom_range(7, 31));
                8, 9:    c = 5'd1;
                default: c = 5'(r);
            endcase
            a = 8'($urandom);
            if ($urandom_range(0, 3) != 0) a[7] = 1'b0;
            run_txn(c, a, 8'($urandom), 2'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iram_responder.md
IRAM_RESPONDER -- requirements
Module: iram_responder

Interface
REQ-001 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port req  input  1  access request; sampled only while busy=0.
REQ-004 SHALL have port RAM_access  input  5  access command from control_unit, valid with req.
REQ-005 SHALL have port addr  input  8  direct address (direct commands) or register index in addr[2:0] (Rn/@Ri commands).
REQ-006 SHALL have port wdata  input  8  write data, valid with req.
REQ-007 SHALL have port bank  input  2  PSW RS1:RS0 register-bank select, valid with req.
REQ-008 SHALL have port busy  output  1  high from the cycle after acceptance until the done cycle, inclusive.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rdata  output  8  read result; held stable until the next done.
REQ-011 SHALL have port err  output  1  qualified by done; flags a rejected access.

Function
REQ-012 SHALL decode RAM_access: 0x00 NOP, 0x01 RD_DIR, 0x02 WR_DIR, 0x03 RD_RN, 0x04 WR_RN, 0x05 RD_IND, 0x06 WR_IND; every other code is illegal.
REQ-013 SHALL accept a request when req=1 and state=IDLE, latching RAM_access, addr, wdata and bank; later changes to these inputs SHALL NOT affect the access in flight.
REQ-014 SHALL ignore req while busy=1 (no queueing, no error).
REQ-015 SHALL implement states IDLE, PTR, ACC, RESP: IDLE->PTR for RD_IND/WR_IND, IDLE->ACC for all other accepted codes, PTR->ACC, ACC->RESP, RESP->IDLE.
REQ-016 SHALL form the Rn address as {bank, addr[2:0]} (0x00-0x1F).
REQ-017 SHALL, in PTR, read pointer = mem[{bank, 2'b00, addr[0]}] (R0/R1 of the latched bank); @Ri uses only addr[0].
REQ-018 SHALL, in ACC, perform the write or capture the read for the effective address (direct addr, Rn address, or pointer).
REQ-019 SHALL assert done=1 only in RESP: 3 cycles after the accepting edge for direct/Rn/NOP/illegal, 4 cycles for indirect.
REQ-020 SHALL treat an effective address >= 0x80 (direct or pointer) as out of range: no write, rdata=0xFF, err=1.
REQ-021 SHALL treat an illegal code identically to REQ-020 (no write, rdata=0xFF, err=1).
REQ-022 SHALL complete NOP with done=1, err=0, no write, rdata unchanged.
REQ-023 SHALL leave rdata unchanged on any write command; err=0 on every successful access.
REQ-024 SHALL return the newly written value for a read issued after the done of a write to the same address.

Reset
REQ-025 SHALL, on reset=1 at a clock edge, force state=IDLE, busy=0, done=0, err=0, rdata=0x00, abandoning any in-flight access with no write performed.
REQ-026 SHALL NOT clear memory contents on reset.
REQ-027 SHALL honour reset in preference to req in the same cycle.

Structure
REQ-028 SHALL place command encodings, state encoding and IRAM_DEPTH=128 in shared package iram_pkg.
REQ-029 SHALL contain exactly one sub-module, iram_array: 128x8, one synchronous write port, one combinational read port.

Verification
REQ-030 WR_DIR addr=0x30 wdata=0xA5, then RD_DIR addr=0x30 -> done at +3 cycles, rdata=0xA5, err=0.
REQ-031 bank=2, WR_RN addr=3 wdata=0x5C, then RD_DIR addr=0x13 -> rdata=0x5C.
REQ-032 bank=1, WR_RN addr=1 wdata=0x40; WR_DIR 0x40<-0x77; RD_IND addr=1 -> done at +4 cycles, rdata=0x77.
REQ-033 RD_DIR addr=0x90; RAM_access=0x1F; RD_IND with pointer 0xC0 -> rdata=0xFF, err=1, no memory change.
REQ-034 req pulsed while busy, then reset asserted during ACC of WR_DIR 0x20<-0x11 -> second req ignored, outputs zero, mem[0x20] unchanged.
